// File: rtl/uart_frame_sender.sv
// Streams one snapshot of N_CH samples into the UART TX FIFO as an ASCII frame:
// '$', DIGITS hex digits per channel separated by ',', then CR LF.
module uart_frame_sender #(
   parameter int N_CH   = 13,
   parameter int DATA_W = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [N_CH*DATA_W-1:0]   samples,
   input  logic                     tx_full,
   output logic                     wr_uart,
   output logic [7:0]               w_data,
   output logic                     busy,
   output logic                     done_tick,
   output logic [2:0]               dbg_state
);

   localparam int DIGITS = DATA_W / 4;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_DIG  = 3'd2;
   localparam logic [2:0] S_SEP  = 3'd3;
   localparam logic [2:0] S_CR   = 3'd4;
   localparam logic [2:0] S_LF   = 3'd5;

   logic [2:0]              state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [DIG_W-1:0]        dig_q, dig_d;
   logic [N_CH*DATA_W-1:0]  shreg_q, shreg_d;
   logic                    done_q, done_d;
   logic [3:0]              nib;
   logic [7:0]              hex_char;
   logic [7:0]              byte_sel;

   // The channel being sent always sits in the low DATA_W bits; its digits
   // shift toward the top of that slot and SEP shifts the next channel in.
   always_comb begin
      nib      = shreg_q[DATA_W-1 -: 4];
      hex_char = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
      wr_uart  = (state_q != S_IDLE) && !tx_full;
      state_d  = state_q;
      ch_d     = ch_q;
      dig_d    = dig_q;
      shreg_d  = shreg_q;
      byte_sel = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d = samples;
               ch_d    = '0;
               dig_d   = '0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            byte_sel = 8'h24;
            if (wr_uart) state_d = S_DIG;
         end
         S_DIG: begin
            byte_sel = hex_char;
            if (wr_uart) begin
               shreg_d[DATA_W-1:0] = shreg_q[DATA_W-1:0] << 4;
               if (dig_q == DIG_LAST) begin
                  dig_d   = '0;
                  state_d = (ch_q == CH_LAST) ? S_CR : S_SEP;
               end else begin
                  dig_d = dig_q + DIG_W'(1);
               end
            end
         end
         S_SEP: begin
            byte_sel = 8'h2C;
            if (wr_uart) begin
               shreg_d = shreg_q >> DATA_W;
               ch_d    = ch_q + CH_W'(1);
               state_d = S_DIG;
            end
         end
         S_CR: begin
            byte_sel = 8'h0D;
            if (wr_uart) state_d = S_LF;
         end
         S_LF: begin
            byte_sel = 8'h0A;
            if (wr_uart) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      w_data = wr_uart ? byte_sel : 8'h00;
      done_d = wr_uart && (state_q == S_LF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         dig_q   <= '0;
         shreg_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         dig_q   <= dig_d;
         shreg_q <= shreg_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done_tick = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: a frame-level byte model plus directed scenarios,
// and a second small instance (2 channels x 8 bits) checked against literals.
module tb_uart_frame_sender;

   localparam int N_CH   = 13;
   localparam int DATA_W = 12;
   localparam int DIGITS = DATA_W / 4;
   localparam int FLEN   = 2 + N_CH * (DIGITS + 1);

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    tx_full = 1'b0;
   logic [N_CH*DATA_W-1:0]  samples = '0;
   logic                    wr_uart, busy, done_tick;
   logic [7:0]              w_data;
   logic [2:0]              dbg_state;

   logic                    start2 = 1'b0;
   logic [15:0]             samples2 = 16'hF09A;
   logic                    wr2, busy2, done2;
   logic [7:0]              w_data2;
   logic [2:0]              dbg_state2;

   uart_frame_sender #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .start(start), .samples(samples),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy),
      .done_tick(done_tick), .dbg_state(dbg_state)
   );

   uart_frame_sender #(.N_CH(2), .DATA_W(8)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .samples(samples2),
      .tx_full(1'b0), .wr_uart(wr2), .w_data(w_data2), .busy(busy2),
      .done_tick(done2), .dbg_state(dbg_state2)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];   // {last_byte_of_frame, byte}
   bit         exp_done = 1'b0;
   logic [7:0] cap[$];
   int         wcyc[$];
   logic [7:0] cap2[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void build_frame(input logic [N_CH*DATA_W-1:0] s);
      string hx = "0123456789ABCDEF";
      exp_q.push_back({1'b0, 8'h24});
      for (int k = 0; k < N_CH; k++) begin
         logic [DATA_W-1:0] v;
         v = s[k*DATA_W +: DATA_W];
         for (int d = 0; d < DIGITS; d++) begin
            int nb;
            nb = int'((v >> (4 * (DIGITS - 1 - d))) & 4'hF);
            exp_q.push_back({1'b0, hx[nb]});
         end
         if (k < N_CH - 1) exp_q.push_back({1'b0, 8'h2C});
      end
      exp_q.push_back({1'b0, 8'h0D});
      exp_q.push_back({1'b1, 8'h0A});
   endfunction

   // Model: a start seen while no frame is outstanding enqueues a whole frame.
   always @(posedge clk) begin
      if (!reset && start && exp_q.size() == 0) build_frame(samples);
   end

   // Compare process: checks every cycle on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_wr_uart", wr_uart, 0);
         chk("rst_w_data", w_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done_tick, 0);
         exp_q.delete();
         exp_done = 1'b0;
      end else begin
         chk("done_tick", done_tick, exp_done);
         chk("busy", busy, exp_q.size() != 0);
         if (wr_uart) begin
            logic [8:0] e;
            chk("write_while_full", tx_full, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", w_data, 32'hFFFF_FFFF);
               exp_done = 1'b0;
            end else begin
               e = exp_q.pop_front();
               chk("w_data", w_data, e[7:0]);
               exp_done = e[8];
            end
            cap.push_back(w_data);
            wcyc.push_back(cyc);
         end else begin
            chk("idle_w_data", w_data, 0);
            if (exp_q.size() != 0 && !tx_full) chk("stalled", wr_uart, 1);
            exp_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && wr2) cap2.push_back(w_data2);
   end

   // ---------------- driver tasks ----------------
   task automatic start_pulse(output int ts);
      @(posedge clk); #1;
      start = 1'b1;
      ts = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc, input int bound);
      dc = -1;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (done_tick) begin
            dc = cyc;
            break;
         end
      end
      chk("done_seen", dc >= 0, 1);
   endtask

   task automatic wait_bytes(input int n, input int bound);
      int i;
      i = 0;
      while (cap.size() < n && i < bound) begin
         @(posedge clk); #1;
         i++;
      end
      chk("bytes_reached", cap.size() >= n, 1);
   endtask

   task automatic set_basic();
      samples = '0;
      samples[0*DATA_W +: DATA_W]  = 12'hABC;
      samples[12*DATA_W +: DATA_W] = 12'h123;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int ts, t2, dc, d1;
      logic [7:0] e2 [8];
      e2 = '{8'h24, 8'h39, 8'h41, 8'h2C, 8'h46, 8'h30, 8'h0D, 8'h0A};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_wr", wr_uart, 0);

      // Basic frame
      set_basic();
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      wait_done(dc, 200);
      chk("basic_len", cap.size(), FLEN);
      chk("basic_b0", cap[0], 8'h24);
      chk("basic_b1", cap[1], 8'h41);
      chk("basic_b3", cap[3], 8'h43);
      chk("basic_b4", cap[4], 8'h2C);
      chk("basic_b49", cap[49], 8'h31);
      chk("basic_b51", cap[51], 8'h33);
      chk("basic_b52", cap[52], 8'h0D);
      chk("basic_b53", cap[53], 8'h0A);
      chk("basic_first_cyc", wcyc[0], ts + 1);
      chk("basic_last_cyc", wcyc[53], ts + 54);
      chk("basic_done_cyc", dc, ts + 55);
      @(posedge clk); #1;
      chk("done_one_cycle", done_tick, 0);

      // Back-pressure on byte 7 for 10 cycles
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      wait_bytes(7, 50);
      tx_full = 1'b1;
      repeat (10) @(posedge clk);
      #1 tx_full = 1'b0;
      wait_done(dc, 200);
      chk("bp_len", cap.size(), FLEN);
      chk("bp_b7", cap[7], 8'h30);
      chk("bp_gap", wcyc[7] - wcyc[6], 11);
      chk("bp_done_cyc", dc, ts + 65);

      // Snapshot and ignored start
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      repeat (10) @(posedge clk);
      #1;
      samples = '1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(dc, 200);
      chk("snap_len", cap.size(), FLEN);
      chk("snap_b30", cap[30], 8'h30);
      chk("snap_b50", cap[50], 8'h32);
      repeat (60) @(posedge clk);
      #1;
      chk("no_second_frame", cap.size(), FLEN);
      chk("snap_idle_busy", busy, 0);
      set_basic();

      // Reset mid-frame
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      wait_bytes(20, 50);
      reset = 1'b1;
      #1;
      chk("midrst_wr", wr_uart, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_wdata", w_data, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      wait_done(dc, 200);
      chk("after_rst_len", cap.size(), FLEN);
      chk("after_rst_b0", cap[0], 8'h24);
      chk("after_rst_b1", cap[1], 8'h41);

      // Back-to-back frames
      cap.delete(); wcyc.delete();
      start_pulse(ts);
      wait_done(d1, 200);
      start = 1'b1;
      t2 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(dc, 200);
      chk("b2b_len", cap.size(), 2 * FLEN);
      chk("b2b_b54", cap[54], 8'h24);
      chk("b2b_second_first", wcyc[54], t2 + 1);
      chk("b2b_gap", wcyc[54] - wcyc[53], 2);
      chk("b2b_last", cap[107], 8'h0A);
      chk("b2b_done_cyc", dc, t2 + 55);

      // Small parameter set: 2 channels x 8 bits
      cap2.delete();
      @(posedge clk); #1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done2) seen = 1;
         end
         chk("p2_done_seen", seen, 1);
      end
      chk("p2_len", cap2.size(), 8);
      for (int i = 0; i < 8; i++) chk("p2_byte", cap2[i], e2[i]);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
